// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO pointer blocks: default geometry
// and Gray/binary conversion helpers sized for the widest legal pointer.
package fifo_pkg;

    localparam int ADDRSIZE_DEFAULT = 4;
    // Widest pointer: ADDRSIZE up to 12 plus the wrap bit.
    localparam int PTR_MAX = 13;

    function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
        logic [PTR_MAX-1:0] b;
        for (int i = 0; i < PTR_MAX; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter; shared by the write and read
// side status blocks to decode the synchronised opposite pointer.
module gray2bin_conv
    import fifo_pkg::*;
#(
    parameter int WIDTH = ADDRSIZE_DEFAULT + 1
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    assign bin = WIDTH'(gray2bin(PTR_MAX'(gray)));

endmodule

// File: rtl/wptr_full_level.sv
// Write-domain pointer/status block: Gray write pointer, binary address,
// registered fill level, almost-full, full and sticky overflow flags.
module wptr_full_level
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE = ADDRSIZE_DEFAULT
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic [ADDRSIZE:0]   wafull_thresh,
    input  logic                wovf_clr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                wafull,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                wovf
);

    localparam int PW = ADDRSIZE + 1;
    localparam logic [PW-1:0] DEPTH = {1'b1, {ADDRSIZE{1'b0}}};

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbinnext;
    logic [PW-1:0] wgraynext;
    logic [PW-1:0] rbin;
    logic [PW-1:0] levnext;
    logic [PW-1:0] thresh_eff;
    logic [PW-1:0] full_ptr;
    logic          accept;
    logic          full_next;
    logic          afull_next;
    logic          ovf_next;

    gray2bin_conv #(.WIDTH(PW)) u_rptr_conv (
        .gray (wq2_rptr),
        .bin  (rbin)
    );

    // winc is a request with no back-pressure: on an edge with winc=1 the
    // write is accepted if wfull=0, otherwise it is dropped and wovf latches.
    always_comb begin
        accept     = winc & ~wfull;
        wbinnext   = wbin + {{ADDRSIZE{1'b0}}, accept};
        wgraynext  = PW'(bin2gray(PTR_MAX'(wbinnext)));
        levnext    = wbinnext - rbin;
        // Full when the write pointer is exactly one lap ahead of the read pointer.
        full_ptr   = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
        full_next  = (wgraynext == full_ptr);
        thresh_eff = (wafull_thresh > DEPTH) ? DEPTH : wafull_thresh;
        afull_next = (wafull_thresh != '0) && (levnext >= thresh_eff);
        ovf_next   = (winc & wfull) | (wovf & ~wovf_clr);
    end

    assign waddr = wbin[ADDRSIZE-1:0];

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin   <= '0;
            wptr   <= '0;
            wfull  <= 1'b0;
            wafull <= 1'b0;
            wlevel <= '0;
            wovf   <= 1'b0;
        end else begin
            wbin   <= wbinnext;
            wptr   <= wgraynext;
            wfull  <= full_next;
            wafull <= afull_next;
            wlevel <= levnext;
            wovf   <= ovf_next;
        end
    end

endmodule

// File: tb/tb_wptr_full_level.sv
// Bench for wptr_full_level (ADDRSIZE=4): directed scenarios plus random
// traffic, scored against an occupancy model built on unbounded counts.
module tb_wptr_full_level;

    logic       wclk = 1'b0;
    logic       wrst_n = 1'b1;
    logic       winc = 1'b0;
    logic [4:0] wq2_rptr = '0;
    logic [4:0] wafull_thresh = '0;
    logic       wovf_clr = 1'b0;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic       wafull;
    logic [4:0] wlevel;
    logic       wovf;

    wptr_full_level #(.ADDRSIZE(4)) dut (
        .wclk          (wclk),
        .wrst_n        (wrst_n),
        .winc          (winc),
        .wq2_rptr      (wq2_rptr),
        .wafull_thresh (wafull_thresh),
        .wovf_clr      (wovf_clr),
        .waddr         (waddr),
        .wptr          (wptr),
        .wfull         (wfull),
        .wafull        (wafull),
        .wlevel        (wlevel),
        .wovf          (wovf)
    );

    always #5 wclk = ~wclk;

    // Expected layout: {waddr, wptr, wfull, wafull, wlevel, wovf}
    logic [16:0] exp_q[$];
    int n_tests = 0;
    int n_fail = 0;

    // Model state: total words ever written / read, plus flags.
    int m_wr = 0;
    int m_rd = 0;
    bit m_full = 0;
    bit m_ovf = 0;
    int cur_thr = 12;
    bit t4_active = 0;
    int t4_max = 0;

    function automatic logic [4:0] gray5(input int v);
        logic [4:0] b;
        b = 5'(v % 32);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit inc, input int rd, input bit clr);
        int lev;
        int teff;
        bit acc;
        bit afl;
        @(negedge wclk);
        winc          = inc;
        wq2_rptr      = gray5(rd);
        wafull_thresh = 5'(cur_thr);
        wovf_clr      = clr;
        acc   = inc && !m_full;
        m_ovf = (inc && m_full) || (m_ovf && !clr);
        if (acc) m_wr++;
        m_rd   = rd;
        lev    = m_wr - m_rd;
        m_full = (lev == 16);
        teff   = (cur_thr > 16) ? 16 : cur_thr;
        afl    = (cur_thr != 0) && (lev >= teff);
        exp_q.push_back({4'(m_wr % 16), gray5(m_wr), m_full, afl, 5'(lev), m_ovf});
    endtask

    task automatic settle();
        @(posedge wclk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge wclk);
        #2;
        wrst_n   = 1'b0;
        winc     = 1'b0;
        wovf_clr = 1'b0;
        wq2_rptr = '0;
        #1;
        check("rst_waddr", int'(waddr), 0);
        check("rst_wptr", int'(wptr), 0);
        check("rst_wfull", int'(wfull), 0);
        check("rst_wafull", int'(wafull), 0);
        check("rst_wlevel", int'(wlevel), 0);
        check("rst_wovf", int'(wovf), 0);
        m_wr = 0; m_rd = 0; m_full = 0; m_ovf = 0;
        repeat (2) @(posedge wclk);
        @(negedge wclk);
        wrst_n = 1'b1;
    endtask

    // Monitor: outputs update every edge, so one expectation is retired per edge.
    initial begin
        logic [16:0] e;
        logic [16:0] act;
        forever begin
            @(posedge wclk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {waddr, wptr, wfull, wafull, wlevel, wovf};
                n_tests++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL cycle_outputs: got waddr=%0d wptr=%b full=%b afull=%b level=%0d ovf=%b, expected waddr=%0d wptr=%b full=%b afull=%b level=%0d ovf=%b",
                             act[16:13], act[12:8], act[7], act[6], act[5:1], act[0],
                             e[16:13], e[12:8], e[7], e[6], e[5:1], e[0]);
                end
                n_tests++;
                if (wfull !== (wlevel == 5'd16)) begin
                    n_fail++;
                    $display("FAIL full_level_equiv: wfull=%b with wlevel=%0d", wfull, wlevel);
                end
                if (t4_active && int'(wlevel) > t4_max) t4_max = int'(wlevel);
            end
        end
    end

    initial begin
        int h1;
        int h2;
        int cur;
        int rd;
        do_reset();

        // Fill from empty with threshold 12.
        cur_thr = 12;
        repeat (16) drive(1, 0, 0);
        settle();
        check("fill_wptr", int'(wptr), 5'b11000);
        check("fill_wfull", int'(wfull), 1);
        check("fill_wlevel", int'(wlevel), 16);
        check("fill_waddr_wrap", int'(waddr), 0);

        // Overflow set, hold, clear, and set-beats-clear.
        drive(1, 0, 0);
        drive(0, 0, 0);
        settle();
        check("ovf_set", int'(wovf), 1);
        check("ovf_wptr_hold", int'(wptr), 5'b11000);
        drive(0, 0, 1);
        settle();
        check("ovf_clr", int'(wovf), 0);
        drive(1, 0, 1);
        settle();
        check("ovf_set_wins", int'(wovf), 1);

        // Read side advances by 4 while full.
        drive(0, 4, 0);
        settle();
        check("rd4_wfull", int'(wfull), 0);
        check("rd4_wlevel", int'(wlevel), 12);
        check("rd4_wafull", int'(wafull), 1);
        drive(0, m_wr, 1);

        // Read pointer trails the write pointer by two cycles.
        h1 = m_wr;
        h2 = m_wr;
        t4_active = 1;
        for (int i = 0; i < 40; i++) begin
            cur = m_wr;
            drive(1, h2, 0);
            h2 = h1;
            h1 = cur;
        end
        settle();
        t4_active = 0;
        n_tests++;
        if (t4_max > 3) begin
            n_fail++;
            $display("FAIL trail_max_level: got %0d, required at most 3", t4_max);
        end
        drive(0, m_wr, 0);

        // Almost-full disabled, then threshold beyond depth.
        cur_thr = 0;
        repeat (16) drive(1, m_rd, 0);
        settle();
        check("thr0_wafull", int'(wafull), 0);
        check("thr0_wfull", int'(wfull), 1);
        drive(0, m_wr, 0);
        cur_thr = 20;
        repeat (15) drive(1, m_rd, 0);
        settle();
        check("thr20_lvl15_wafull", int'(wafull), 0);
        drive(1, m_rd, 0);
        settle();
        check("thr20_lvl16_wafull", int'(wafull), 1);
        check("thr20_lvl16_wfull", int'(wfull), 1);

        // Reset at level 9 with overflow pending.
        drive(1, m_rd, 0);
        drive(0, m_wr - 9, 0);
        settle();
        check("pre_rst_wlevel", int'(wlevel), 9);
        check("pre_rst_wovf", int'(wovf), 1);
        do_reset();
        cur_thr = 12;
        drive(1, 0, 0);
        settle();
        check("post_rst_wlevel", int'(wlevel), 1);
        check("post_rst_waddr", int'(waddr), 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rd = m_rd;
            if ($urandom_range(0, 3) == 0) rd = m_rd + int'($urandom_range(0, m_wr - m_rd));
            if ($urandom_range(0, 15) == 0) cur_thr = int'($urandom_range(0, 31));
            drive($urandom_range(0, 3) != 0, rd, $urandom_range(0, 7) == 0);
        end

        repeat (3) @(posedge wclk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
